// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - pipeline/memory-side signal bundle for the posted-store buffer
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [2:0]        st_ctrl;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_ctrl;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic              ld_stall;

  logic              dm_wre;
  logic [ADDR_W-1:0] dm_address;
  logic [31:0]       dm_data_write;
  logic [2:0]        dm_ctrl;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, st_ctrl,
    output ld_valid, ld_addr, ld_ctrl,
    input  st_ready, fwd_hit, fwd_data, ld_stall,
    input  dm_wre, dm_address, dm_data_write, dm_ctrl,
    input  empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_ctrl,
    input  ld_valid, ld_addr, ld_ctrl,
    output st_ready, fwd_hit, fwd_data, ld_stall,
    output dm_wre, dm_address, dm_data_write, dm_ctrl,
    output empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO draining into dm, with store-to-load forwarding
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SPAN_W = ADDR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [2:0]        size_q [DEPTH];
  logic [2:0]        size_d [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              st_ready;
  logic              empty;
  logic              push;
  logic              pop;

  // Last byte offset of an access (N-1), for size codes b/h/w and bu/hu.
  function automatic logic [SPAN_W-1:0] span_last(input logic [1:0] sz);
    case (sz)
      2'b00:   span_last = SPAN_W'(0);
      2'b01:   span_last = SPAN_W'(1);
      default: span_last = SPAN_W'(3);
    endcase
  endfunction

  assign st_ready = count_q < CNT_W'(DEPTH);
  assign empty    = count_q == '0;
  assign push     = sb.st_valid && st_ready;
  assign pop      = !empty && !sb.ld_valid;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q] = sb.st_addr;
      data_d[tail_q] = sb.st_data;
      size_d[tail_q] = sb.st_ctrl;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads are never read outside the occupied window, so they skip reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
  end

  logic              match_found;
  logic [PTR_W-1:0]  match_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [SPAN_W-1:0] l_lo, l_hi;
  logic [SPAN_W-1:0] e_lo, e_hi;
  logic [SPAN_W-1:0] m_lo, m_hi;
  logic [SPAN_W-1:0] offset;
  logic              contained;
  logic [31:0]       shifted;
  logic [31:0]       extended;

  // Oldest to youngest, so the last intersecting entry seen is the youngest one.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    scan_idx    = '0;
    e_lo        = '0;
    e_hi        = '0;
    l_lo        = {1'b0, sb.ld_addr};
    l_hi        = l_lo + span_last(sb.ld_ctrl[1:0]);
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      e_lo     = {1'b0, addr_q[scan_idx]};
      e_hi     = e_lo + span_last(size_q[scan_idx][1:0]);
      if ((CNT_W'(i) < count_q) && (e_lo <= l_hi) && (l_lo <= e_hi)) begin
        match_found = 1'b1;
        match_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    m_lo      = {1'b0, addr_q[match_idx]};
    m_hi      = m_lo + span_last(size_q[match_idx][1:0]);
    contained = (m_lo <= l_lo) && (l_hi <= m_hi);
    offset    = l_lo - m_lo;
    shifted   = data_q[match_idx] >> {offset[1:0], 3'b000};
    case (sb.ld_ctrl)
      3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extended = {24'b0, shifted[7:0]};
      3'b101:  extended = {16'b0, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  assign sb.fwd_hit  = sb.ld_valid && match_found && contained;
  assign sb.ld_stall = sb.ld_valid && match_found && !contained;
  assign sb.fwd_data = sb.fwd_hit ? extended : 32'b0;

  assign sb.st_ready      = st_ready;
  assign sb.empty         = empty;
  assign sb.count         = count_q;
  assign sb.dm_wre        = pop;
  assign sb.dm_address    = empty ? '0 : addr_q[head_q];
  assign sb.dm_data_write = empty ? 32'b0 : data_q[head_q];
  assign sb.dm_ctrl       = empty ? 3'b0 : size_q[head_q];
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer against a byte-level pending-store model
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) sb ();
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .sb(sb));

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [2:0]  c;
  } st_t;

  typedef struct {
    logic        rdy;
    logic        emp;
    logic [31:0] cnt;
    logic        wre;
    logic        hit;
    logic        stall;
    logic [31:0] fd;
    logic [9:0]  da;
    logic [31:0] dd;
    logic [2:0]  dc;
  } exp_t;

  st_t  pend[$];
  st_t  exp_wr_q[$];
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  logic        dchk_en = 1'b0;
  string       dchk_name;
  logic        dchk_hit, dchk_stall;
  logic [31:0] dchk_data, dchk_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic covers(input st_t s, input int b);
    return (b >= int'(s.a)) && (b < int'(s.a) + nbytes(s.c[1:0]));
  endfunction

  task automatic ld_model(input logic [9:0] la, input logic [2:0] lc,
                          output logic hit, output logic stall, output logic [31:0] fd);
    int n, y, b, off;
    logic full;
    logic [31:0] raw, w;
    n = nbytes(lc[1:0]);
    y = -1;
    for (int k = 0; k < n; k++) begin
      b = int'(la) + k;
      for (int j = pend.size() - 1; j >= 0; j--) begin
        if (covers(pend[j], b)) begin
          if (j > y) y = j;
          break;
        end
      end
    end
    hit = 1'b0; stall = 1'b0; fd = 32'b0;
    if (y >= 0) begin
      full = 1'b1;
      raw  = 32'b0;
      for (int k = 0; k < n; k++) begin
        b = int'(la) + k;
        if (!covers(pend[y], b)) full = 1'b0;
        else begin
          off = b - int'(pend[y].a);
          w   = (pend[y].d >> (8 * off)) & 32'hFF;
          raw = raw | (w << (8 * k));
        end
      end
      if (full) begin
        hit = 1'b1;
        case (lc)
          3'b000:  fd = {{24{raw[7]}}, raw[7:0]};
          3'b001:  fd = {{16{raw[15]}}, raw[15:0]};
          3'b100:  fd = {24'b0, raw[7:0]};
          3'b101:  fd = {16'b0, raw[15:0]};
          default: fd = raw;
        endcase
      end else begin
        stall = 1'b1;
      end
    end
  endtask

  task automatic dcheck(input string name, input logic h, input logic s,
                        input logic [31:0] d, input logic [31:0] c);
    dchk_en = 1'b1; dchk_name = name;
    dchk_hit = h; dchk_stall = s; dchk_data = d; dchk_cnt = c;
  endtask

  task automatic cyc(input logic rs, input logic sv, input logic [9:0] sa, input logic [31:0] sd,
                     input logic [2:0] sc, input logic lv, input logic [9:0] la, input logic [2:0] lc);
    exp_t e;
    st_t  s;
    logic acc;
    rst = rs;
    sb.st_valid = sv; sb.st_addr = sa; sb.st_data = sd; sb.st_ctrl = sc;
    sb.ld_valid = lv; sb.ld_addr = la; sb.ld_ctrl = lc;
    acc = sv && (pend.size() < DEPTH);
    if (chk_on) begin
      e.rdy = pend.size() < DEPTH;
      e.emp = pend.size() == 0;
      e.cnt = pend.size();
      e.wre = (pend.size() > 0) && !lv;
      if (lv) ld_model(la, lc, e.hit, e.stall, e.fd);
      else begin e.hit = 1'b0; e.stall = 1'b0; e.fd = 32'b0; end
      e.da = (pend.size() > 0) ? pend[0].a : 10'b0;
      e.dd = (pend.size() > 0) ? pend[0].d : 32'b0;
      e.dc = (pend.size() > 0) ? pend[0].c : 3'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (dchk_en) begin
      chk({dchk_name, "_hit"}, 32'(sb.fwd_hit), 32'(dchk_hit));
      chk({dchk_name, "_stall"}, 32'(sb.ld_stall), 32'(dchk_stall));
      chk({dchk_name, "_data"}, sb.fwd_data, dchk_data);
      chk({dchk_name, "_count"}, 32'(sb.count), dchk_cnt);
      dchk_en = 1'b0;
    end
    @(posedge clk);
    if (rs) begin
      pend.delete();
      exp_wr_q.delete();
    end else begin
      if ((pend.size() > 0) && !lv) void'(pend.pop_front());
      if (acc) begin
        s.a = sa; s.d = sd; s.c = sc;
        pend.push_back(s);
        exp_wr_q.push_back(s);
      end
    end
    #1;
  endtask

  exp_t mon_e;
  st_t  mon_w;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("st_ready", 32'(sb.st_ready), 32'(mon_e.rdy));
      chk("empty", 32'(sb.empty), 32'(mon_e.emp));
      chk("count", 32'(sb.count), mon_e.cnt);
      chk("dm_wre", 32'(sb.dm_wre), 32'(mon_e.wre));
      chk("fwd_hit", 32'(sb.fwd_hit), 32'(mon_e.hit));
      chk("ld_stall", 32'(sb.ld_stall), 32'(mon_e.stall));
      chk("fwd_data", sb.fwd_data, mon_e.fd);
      if (sb.dm_wre === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dm_write: got unexpected write at %h expected none", sb.dm_address);
        end else begin
          mon_w = exp_wr_q.pop_front();
          chk("dm_address", 32'(sb.dm_address), 32'(mon_w.a));
          chk("dm_data_write", sb.dm_data_write, mon_w.d);
          chk("dm_ctrl", 32'(sb.dm_ctrl), 32'(mon_w.c));
        end
      end else begin
        chk("dm_address_idle", 32'(sb.dm_address), 32'(mon_e.da));
        chk("dm_data_idle", sb.dm_data_write, mon_e.dd);
        chk("dm_ctrl_idle", 32'(sb.dm_ctrl), 32'(mon_e.dc));
      end
    end
  end

  logic [2:0] ld_codes [5];
  logic [2:0] sz, lz;

  initial begin
    ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
    ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;

    // Fill with a load holding the port, then a refused fifth store.
    dcheck("reset", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 10'(4 * i), 32'hA0 + 32'(i), 3'b010, 1, 10'h300, 3'b010);
    cyc(0, 0, 0, 0, 0, 1, 10'h300, 3'b010);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Forwarding with sign and zero extension.
    cyc(0, 1, 10'h010, 32'h8899AABB, 3'b010, 1, 10'h300, 3'b010);
    dcheck("lb_fwd", 1, 0, 32'hFFFFFF88, 1);
    cyc(0, 0, 0, 0, 0, 1, 10'h013, 3'b000);
    dcheck("lhu_fwd", 1, 0, 32'h0000AABB, 1);
    cyc(0, 0, 0, 0, 0, 1, 10'h010, 3'b101);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Partial overlap stalls until both stores drain.
    cyc(0, 1, 10'h020, 32'h11111111, 3'b010, 1, 10'h300, 3'b010);
    cyc(0, 1, 10'h021, 32'h00000022, 3'b000, 1, 10'h300, 3'b010);
    dcheck("lw_stall", 0, 1, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 10'h020, 3'b010);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    dcheck("lw_reissue", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 10'h020, 3'b010);

    // Full buffer with a same-cycle drain refuses the push, then streams at count 3.
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 10'h080 + 10'(4 * i), 32'hB0 + 32'(i), 3'b010, 1, 10'h300, 3'b010);
    dcheck("full_pop", 0, 0, 0, 4);
    cyc(0, 1, 10'h0A0, 32'hC0, 3'b010, 0, 0, 0);
    dcheck("stream_a", 0, 0, 0, 3);
    cyc(0, 1, 10'h0A0, 32'hC0, 3'b010, 0, 0, 0);
    dcheck("stream_b", 0, 0, 0, 3);
    cyc(0, 1, 10'h0A4, 32'hC1, 3'b010, 0, 0, 0);

    // Reset while draining discards the rest.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    dcheck("after_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      sz = 3'($urandom_range(0, 2));
      lz = ld_codes[$urandom_range(0, 4)];
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
          10'h040 + 10'($urandom_range(0, 15)), $urandom, sz,
          ($urandom_range(0, 1) == 1), 10'h040 + 10'($urandom_range(0, 19)), lz);
    end

    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("leftover_writes", 32'(exp_wr_q.size()), 32'd0);
    chk("leftover_status", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
